// File: rtl/seven_seg_scan_driver.sv
// Scanned multi-digit seven-segment driver: shadow digit registers, per-digit dwell with
// a leading guard cycle, leading-zero blanking, per-digit decimal point and blinking.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    output logic [6:0]              seven_seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    frame_o
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h49;
        endcase
    endfunction

    logic [DW-1:0]           dwell_q, dwell_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_on_q, blink_on_d;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blink_q;

    logic [3:0]              slot_digit_q;
    logic                    slot_dp_q;
    logic                    slot_blink_q;
    logic                    slot_uz_q;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    zero_acc;
    logic [3:0]              sel_digit;
    logic                    sel_dp;
    logic                    sel_blink;
    logic                    sel_uz;
    logic                    guard;
    logic                    dwell_wrap;
    logic                    frame_wrap;

    // upper_zero[k]: shadow digits k..NUM_DIGITS-1 are all zero; digit 0 is never blanked.
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_acc      = zero_acc & (digits_q[4*k +: 4] == 4'd0);
            upper_zero[k] = zero_acc;
        end
    end

    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_uz    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_digit = digits_q[4*k +: 4];
                sel_dp    = dp_q[k];
                sel_blink = blink_q[k];
                sel_uz    = upper_zero[k];
            end
        end
    end

    always_comb begin
        guard       = (dwell_q == '0);
        dwell_wrap  = (dwell_q == DWELL_LAST);
        frame_wrap  = dwell_wrap && (idx_q == IDX_LAST);

        dwell_d     = dwell_wrap ? '0 : dwell_q + DW'(1);
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (dwell_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // Active cycles show the slot latched at the guard; blanking and blink only mask it.
        seg_d    = decode(slot_digit_q);
        dp_out_d = slot_dp_q;
        if (blank_lz_i && slot_uz_q) begin
            seg_d = '0;
        end
        if (!blink_on_q && slot_blink_q) begin
            seg_d    = '0;
            dp_out_d = 1'b0;
        end
        en_d    = NUM_DIGITS'(1) << idx_q;
        frame_d = 1'b0;
        if (guard) begin
            seg_d    = '0;
            dp_out_d = 1'b0;
            en_d     = '0;
            frame_d  = (idx_q == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell_q      <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            digits_q     <= '0;
            dp_q         <= '0;
            blink_q      <= '0;
            slot_digit_q <= '0;
            slot_dp_q    <= 1'b0;
            slot_blink_q <= 1'b0;
            slot_uz_q    <= 1'b0;
            seg_q        <= '0;
            dp_out_q     <= 1'b0;
            en_q         <= '0;
            frame_q      <= 1'b0;
        end else begin
            dwell_q     <= dwell_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            if (load_i) begin
                digits_q <= digits_i;
                dp_q     <= dp_i;
                blink_q  <= blink_i;
            end
            // Slot latch reads the pre-edge shadow, so a load on the guard cycle shows next slot.
            if (guard) begin
                slot_digit_q <= sel_digit;
                slot_dp_q    <= sel_dp;
                slot_blink_q <= sel_blink;
                slot_uz_q    <= sel_uz;
            end
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            en_q     <= en_d;
            frame_q  <= frame_d;
        end
    end

    assign seven_seg_o = seg_q;
    assign dp_o        = dp_out_q;
    assign digit_en_o  = en_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, dwell 4, blink 2 frames):
// cycle scoreboard from a time-based model, a vector table, and load/reset corner sequences.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int DC = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * DC;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   digits_i = '0;
    logic          load_i = 1'b0;
    logic          blank_lz_i = 1'b0;
    logic [3:0]    dp_i = '0;
    logic [3:0]    blink_i = '0;
    logic [6:0]    seven_seg_o;
    logic          dp_o;
    logic [3:0]    digit_en_o;
    logic          frame_o;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .digits_i   (digits_i),
        .load_i     (load_i),
        .blank_lz_i (blank_lz_i),
        .dp_i       (dp_i),
        .blink_i    (blink_i),
        .seven_seg_o(seven_seg_o),
        .dp_o       (dp_o),
        .digit_en_o (digit_en_o),
        .frame_o    (frame_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard and model state ----------------
    logic [12:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          t = 0;

    logic [6:0]  dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h49, 7'h49, 7'h49, 7'h49, 7'h49, 7'h49};
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_blink;
    logic [3:0]  sl_dig;
    logic        sl_dp, sl_bl, sl_uz;
    logic [6:0]  got_seg [4];
    logic        got_dp [4];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] segs;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_digits = '0;
        m_dp = '0;
        m_blink = '0;
        sl_dig = '0;
        sl_dp = 1'b0;
        sl_bl = 1'b0;
        sl_uz = 1'b0;
        exp_q.delete();
    endtask

    // One clock: predict the output after this edge from the pre-edge model, then compare.
    task automatic step();
        logic        pre_load, pre_blz, on;
        logic [15:0] pre_digits;
        logic [3:0]  pre_dp, pre_blink;
        logic [6:0]  seg;
        logic        d;
        logic [12:0] e, got;
        int          p, s, ph;
        pre_load   = load_i;
        pre_blz    = blank_lz_i;
        pre_digits = digits_i;
        pre_dp     = dp_i;
        pre_blink  = blink_i;
        @(posedge clk_i);
        t++;
        p  = (t - 1) % FRAME;
        s  = p / DC;
        ph = p % DC;
        if (ph == 0) begin
            e      = {(s == 0), 4'b0000, 1'b0, 7'h00};
            sl_dig = m_digits[4*s +: 4];
            sl_dp  = m_dp[s];
            sl_bl  = m_blink[s];
            sl_uz  = (s >= 1) && ((m_digits >> (4 * s)) == 16'h0);
        end else begin
            on  = ((((t - 1) / FRAME) / BF) % 2) == 0;
            seg = dec_tab[sl_dig];
            if (pre_blz && sl_uz) seg = 7'h00;
            d = sl_dp;
            if (!on && sl_bl) begin
                seg = 7'h00;
                d   = 1'b0;
            end
            e = {1'b0, 4'b0001 << s, d, seg};
        end
        if (pre_load) begin
            m_digits = pre_digits;
            m_dp     = pre_dp;
            m_blink  = pre_blink;
        end
        exp_q.push_back(e);
        #1;
        got = {frame_o, digit_en_o, dp_o, seven_seg_o};
        check("scan", 32'(got), 32'(exp_q.pop_front()));
        if (ph == 1) begin
            got_seg[s] = seven_seg_o;
            got_dp[s]  = dp_o;
        end
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((t % FRAME) == pos) break;
            step();
        end
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        load_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_outputs", 32'({frame_o, digit_en_o, dp_o, seven_seg_o}), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic load_and_settle(input logic [15:0] dg, input logic [3:0] dp,
                                   input logic [3:0] bl, input logic blz);
        digits_i   = dg;
        dp_i       = dp;
        blink_i    = bl;
        blank_lz_i = blz;
        load_i     = 1'b1;
        step();
        load_i = 1'b0;
        step();
        run_to(0);
    endtask

    initial begin
        int n_on, n_dark, n_frames;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
        vecs[3] = '{16'h0B00, 4'b0000, 1'b0, {7'h3F, 7'h49, 7'h3F, 7'h3F}, 4'b0000};
        vecs[4] = '{16'h0007, 4'b1010, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b1010};
        vecs[5] = '{16'h9806, 4'b0000, 1'b1, {7'h6F, 7'h7F, 7'h3F, 7'h7D}, 4'b0000};

        model_reset();
        do_reset();

        step();
        check("first_frame_pulse", 32'(frame_o), 32'd1);

        // Vector table: one full frame after the load, per-digit segments and dp.
        for (int v = 0; v < 6; v++) begin
            load_and_settle(vecs[v].digits, vecs[v].dp, 4'b0000, vecs[v].blz);
            for (int i = 0; i < FRAME; i++) step();
            for (int k = 0; k < ND; k++) begin
                check($sformatf("vec%0d_seg%0d", v, k), 32'(got_seg[k]), 32'(vecs[v].segs[7*k +: 7]));
                check($sformatf("vec%0d_dp%0d", v, k), 32'(got_dp[k]), 32'(vecs[v].exp_dp[k]));
            end
        end

        // Load in the second cycle of the digit-1 slot: the slot keeps its old content.
        load_and_settle(16'h1234, 4'b0000, 4'b0000, 1'b0);
        run_to(6);
        digits_i = 16'h1294;
        load_i   = 1'b1;
        step();
        load_i = 1'b0;
        check("midslot_old", 32'(seven_seg_o), 32'h4F);
        run_to(6);
        check("midslot_new", 32'(seven_seg_o), 32'h6F);

        // Load coincident with the digit-2 guard: old value shown in that slot.
        run_to(8);
        digits_i = 16'h1734;
        load_i   = 1'b1;
        step();
        load_i = 1'b0;
        step();
        check("guard_load_old", 32'(seven_seg_o), 32'h5B);
        for (int i = 0; i < FRAME; i++) step();
        check("guard_load_new", 32'(seven_seg_o), 32'h07);

        // Blink on digit 0: two visible frames, two dark frames.
        load_and_settle(16'h0008, 4'b0001, 4'b0001, 1'b0);
        n_on = 0;
        n_dark = 0;
        n_frames = 0;
        for (int i = 0; i < 2 * BF * FRAME; i++) begin
            step();
            if (frame_o) n_frames++;
            if (digit_en_o == 4'b0001 && seven_seg_o == 7'h7F && dp_o) n_on++;
            if (digit_en_o == 4'b0001 && seven_seg_o == 7'h00 && !dp_o) n_dark++;
        end
        check("blink_visible_cycles", 32'(n_on), 32'(BF * (DC - 1)));
        check("blink_dark_cycles", 32'(n_dark), 32'(BF * (DC - 1)));
        check("frame_pulses", 32'(n_frames), 32'(2 * BF));

        // Asynchronous reset in the middle of an active slot.
        run_to(2);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_reset_outputs", 32'({frame_o, digit_en_o, dp_o, seven_seg_o}), 32'h0);
        do_reset();
        step();
        check("restart_frame_pulse", 32'(frame_o), 32'd1);
        check("restart_guard_en", 32'(digit_en_o), 32'h0);
        step();
        check("restart_digit0_en", 32'(digit_en_o), 32'h1);
        check("restart_digit0_seg", 32'(seven_seg_o), 32'h3F);
        for (int i = 0; i < $urandom_range(3, 20); i++) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
